// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router input port: flit field positions,
// request codes and the XY routing function.
package noc_pkg;

  localparam int FLIT_W    = 8;
  localparam int ROUTE_W   = 3;
  localparam int DEST_X_HI = 7;
  localparam int DEST_X_LO = 6;
  localparam int DEST_Y_HI = 5;
  localparam int DEST_Y_LO = 4;

  localparam logic [ROUTE_W-1:0] REQ_L    = 3'd0;
  localparam logic [ROUTE_W-1:0] REQ_N    = 3'd1;
  localparam logic [ROUTE_W-1:0] REQ_E    = 3'd2;
  localparam logic [ROUTE_W-1:0] REQ_S    = 3'd3;
  localparam logic [ROUTE_W-1:0] REQ_W    = 3'd4;
  localparam logic [ROUTE_W-1:0] REQ_IDLE = 3'd7;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [ROUTE_W-1:0] xy_route(
    input logic [FLIT_W-1:0] flit,
    input logic [1:0]        x_addr,
    input logic [1:0]        y_addr
  );
    logic [1:0] dest_x;
    logic [1:0] dest_y;
    dest_x = flit[DEST_X_HI:DEST_X_LO];
    dest_y = flit[DEST_Y_HI:DEST_Y_LO];
    if (dest_x > x_addr)      return REQ_E;
    else if (dest_x < x_addr) return REQ_W;
    else if (dest_y > y_addr) return REQ_N;
    else if (dest_y < y_addr) return REQ_S;
    else                      return REQ_L;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Generic synchronous FIFO with registered pointers and occupancy count.
// Head is read straight from storage, so it depends on registered state only.
// Push while full and pop while empty are ignored internally.
module noc_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/noc_input_port.sv
// Input stage of the 5-port NoC router: buffers upstream flits together with
// their XY route and presents the head flit/request to the switch.
// Optional forwarded-flit counter enabled by macro NOC_PORT_STATS_EN.
module noc_input_port
  import noc_pkg::*;
#(
  parameter logic [1:0] X_ADDR = 2'd0,
  parameter logic [1:0] Y_ADDR = 2'd0,
  parameter int         DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_data,
  output logic [2:0]        request,
  input  logic              grant
`ifdef NOC_PORT_STATS_EN
  ,
  output logic [15:0]       flit_cnt
`endif
);

  localparam int ENTRY_W = FLIT_W + ROUTE_W;

  logic               ready_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] wr_entry;

  // ready_q keeps in_ready low during reset and for the release edge.
  always_ff @(posedge clk) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  assign in_ready = ready_q & ~full;
  assign push     = in_valid & in_ready;
  // A grant only counts when a real request was presented this cycle.
  assign pop      = grant & ~empty;
  assign wr_entry = {in_data, xy_route(in_data, X_ADDR, Y_ADDR)};

  noc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign out_data = empty ? '0 : head[ENTRY_W-1:ROUTE_W];
  assign request  = empty ? REQ_IDLE : head[ROUTE_W-1:0];

`ifdef NOC_PORT_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d;

  // Saturating count of flits handed to the switch.
  always_comb begin
    flit_cnt_d = flit_cnt_q;
    if (pop && (flit_cnt_q != 16'hFFFF)) flit_cnt_d = flit_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) flit_cnt_q <= '0;
    else      flit_cnt_q <= flit_cnt_d;
  end

  assign flit_cnt = flit_cnt_q;
`endif

endmodule
